// File: rtl/rca_aproximado_pipe.sv
// Two-stage valid/ready approximate ripple-carry adder: LSB cells approximate, the rest exact.
// Optional on-line error statistics are built when ERROR_STATS_EN is defined.
module rca_aproximado_pipe #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned APPROX_BITS = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               cin,
  input  logic               mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     sum,
  output logic               out_mode,
  input  logic               stat_clear,
  output logic [CNT_W-1:0]   err_count,
  output logic [WIDTH:0]     err_max
);

  logic             v1_q, v2_q;
  logic [WIDTH-1:0] a1_q, b1_q;
  logic             cin1_q, mode1_q;
  logic             en1, en2;
  logic [WIDTH:0]   sum_ex, sum_ap, sum_sel;

  assign en2       = ~v2_q | out_ready;
  assign en1       = ~v1_q | en2;
  assign in_ready  = en1;
  assign out_valid = v2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q    <= 1'b0;
      a1_q    <= '0;
      b1_q    <= '0;
      cin1_q  <= 1'b0;
      mode1_q <= 1'b0;
    end else if (en1) begin
      v1_q <= in_valid;
      if (in_valid) begin
        a1_q    <= a;
        b1_q    <= b;
        cin1_q  <= cin;
        mode1_q <= mode;
      end
    end
  end

  // Both ripple chains evaluated bit by bit from the stage-1 registers.
  always_comb begin
    logic c_ex, c_ap, c_nx;
    c_ex   = cin1_q;
    c_ap   = cin1_q;
    c_nx   = 1'b0;
    sum_ex = '0;
    sum_ap = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      sum_ex[i] = a1_q[i] ^ b1_q[i] ^ c_ex;
      c_ex      = (a1_q[i] & b1_q[i]) | (a1_q[i] & c_ex) | (b1_q[i] & c_ex);
      if (i < int'(APPROX_BITS)) begin
        sum_ap[i] = a1_q[i] | b1_q[i] | c_ap;
        c_nx      = a1_q[i] & b1_q[i];
      end else begin
        sum_ap[i] = a1_q[i] ^ b1_q[i] ^ c_ap;
        c_nx      = (a1_q[i] & b1_q[i]) | (a1_q[i] & c_ap) | (b1_q[i] & c_ap);
      end
      c_ap = c_nx;
    end
    sum_ex[WIDTH] = c_ex;
    sum_ap[WIDTH] = c_ap;
  end

  assign sum_sel = mode1_q ? sum_ap : sum_ex;

  always_ff @(posedge clk) begin
    if (rst) begin
      v2_q     <= 1'b0;
      sum      <= '0;
      out_mode <= 1'b0;
    end else if (en2) begin
      v2_q <= v1_q;
      if (v1_q) begin
        sum      <= sum_sel;
        out_mode <= mode1_q;
      end
    end
  end

`ifdef ERROR_STATS_EN
  logic [WIDTH:0]   diff_d, diff_q, max_q;
  logic [CNT_W-1:0] cnt_q;

  assign diff_d = (sum_ex >= sum_ap) ? (sum_ex - sum_ap) : (sum_ap - sum_ex);

  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
    end else if (en2 && v1_q) begin
      diff_q <= diff_d;
    end
  end

  // Clear wins over an update landing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      cnt_q <= '0;
      max_q <= '0;
    end else if (v2_q && out_ready && out_mode) begin
      if ((diff_q != '0) && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (diff_q > max_q) begin
        max_q <= diff_q;
      end
    end
  end

  assign err_count = cnt_q;
  assign err_max   = max_q;
`else
  logic unused_stat_clear;
  assign unused_stat_clear = stat_clear;
  assign err_count         = '0;
  assign err_max           = '0;
`endif

endmodule

// File: doc/rca_aproximado_pipe.md
Name: rca_aproximado_pipe

Overview:
- Parametrised, pipelined successor to the 8-bit combinational approximate ripple-carry adder.
- Generic WIDTH; the lowest APPROX_BITS positions use approximate full-adder cells, the rest use exact cells.
- Per-transaction mode selects the exact or the approximate result.
- Two-stage valid/ready pipeline, with optional on-line error statistics for characterising the approximate adder inside the Tarea test harnesses.

Parameters:
- WIDTH, 8: operand width in bits, minimum 2.
- APPROX_BITS, 1: number of LSB positions built from approximate cells, range 0..WIDTH. A value of 0 gives a fully exact adder.
- CNT_W, 16: width of the error-statistics counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- mode  in  1  0 = exact result, 1 = approximate result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- sum  out  WIDTH+1  result. MSB is the final carry; there is no separate Cout port.
- out_mode  out  1  mode that travelled with the beat.
- stat_clear  in  1  synchronous clear of the statistics.
- err_count  out  CNT_W  number of approximate beats whose result differed from exact.
- err_max  out  WIDTH+1  largest |exact − approximate| seen.

Behaviour:
- Clocking and reset: one clock, clk; reset rst is synchronous, active-high.
- Reset values: out_valid=0, sum=0, out_mode=0, err_count=0, err_max=0, internal valid flags v1=v2=0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: all in-flight beats are discarded with no output handshake; statistics are cleared.
- Cell definitions, bit i:
  - Exact cell: s_i = a_i ^ b_i ^ c_i; c_(i+1) = majority(a_i, b_i, c_i).
  - Approximate cell (i < APPROX_BITS): s_i = a_i | b_i | c_i; c_(i+1) = a_i & b_i.
  - c_0 = cin; sum[WIDTH] = c_WIDTH.
- Stage 1 registers a, b, cin and mode.
- Stage 2 computes both the exact and the approximate result from the stage-1 registers, then registers the result selected by mode onto sum/out_mode. The absolute difference is registered alongside when ERROR_STATS_EN is defined.
- Handshake:
  - en2 = ~v2 | out_ready; en1 = ~v1 | en2; in_ready = en1.
  - A beat is accepted when in_valid & in_ready.
  - A beat is consumed when out_valid & out_ready.
  - Stage registers load only when their enable is high.
  - out_valid = v2.
- Latency: 2 cycles from acceptance to out_valid when there is no stall. Throughput is 1 beat per cycle with out_ready held high.
- Backpressure: with out_ready=0 the pipeline holds 2 beats and in_ready deasserts. sum and out_mode stay stable while out_valid=1 and out_ready=0.
- A simultaneous accept and consume on a full pipeline is legal and loses no beat.
- sum is exact modulo 2^(WIDTH+1); it never overflows.

Optional Feature:
- Macro: ERROR_STATS_EN.
- When defined, the statistics update on each consumed beat with out_mode=1:
  - If the difference is nonzero, err_count increments, saturating at all-ones.
  - err_max is updated to max(err_max, difference).
  - stat_clear takes priority over an update in the same cycle.
- When not defined, err_count and err_max are tied to 0, stat_clear is ignored, and no exact-path comparison logic is synthesised. Both ports remain present.

Test Plan:
- WIDTH=8, APPROX_BITS=1, mode=1, a=0x01, b=0x01, cin=0 -> sum=0x003 two cycles after accept. With ERROR_STATS_EN: err_count=1, err_max=1.
- Same configuration, mode=1, a=0xFF, b=0x01, cin=0 -> sum=0x101 (exact result would be 0x100). a=0x0F, b=0xF0 -> sum=0x0FF and err_count is unchanged.
- mode=0, a=200, b=100, cin=1 -> sum=0x12D, out_mode=0, statistics untouched. APPROX_BITS=0 with mode=1 gives identical results.
- Backpressure: out_ready=0, drive 3 back-to-back beats -> only 2 accepted, in_ready=0 on the third. Raising out_ready drains them in order, one per cycle, with values unchanged.
- Streaming: 100 random beats with out_ready randomly toggled -> results match the cell-level reference model in order, with no drops or duplicates.
- Reset mid-stream with 2 beats in flight -> out_valid=0 the next cycle, err_count=0, no stale beat emitted. stat_clear asserted together with an erroneous consume -> counters read 0.
